// File: rtl/polyline_gen.sv
// Polyline rasteriser: buffers incoming points in a small FIFO and walks
// Bresenham segments between them, emitting one registered pixel per handshake.
module polyline_gen #(
  parameter int COORD_W    = 12,
  parameter int COLOR_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      pt_valid_in,
  output logic                      pt_ready_out,
  input  logic signed [COORD_W-1:0] pt_x_in,
  input  logic signed [COORD_W-1:0] pt_y_in,
  input  logic [COLOR_W-1:0]        pt_color_in,
  input  logic                      pt_new_in,
  input  logic                      pt_close_in,
  output logic                      px_valid_out,
  input  logic                      px_ready_in,
  output logic signed [COORD_W-1:0] px_x_out,
  output logic signed [COORD_W-1:0] px_y_out,
  output logic [COLOR_W-1:0]        px_color_out,
  output logic                      px_seg_last_out,
  output logic                      busy_out
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int DW    = COORD_W + 1;
  localparam int EW    = COORD_W + 2;
  localparam int ENT_W = 2 * COORD_W + COLOR_W + 2;
  localparam logic signed [COORD_W-1:0] ONE     = 1;
  localparam logic [DW-1:0]             CNT_ONE = 1;
  localparam logic [AW:0]               PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, CLOSE} state_t;

  logic [ENT_W-1:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]               wrPtr_q, rdPtr_q;
  logic                      readyEn_q;
  logic                      fifoEmpty, fifoFull, push, pop, advance;
  logic [ENT_W-1:0]          head;
  logic signed [COORD_W-1:0] headX, headY;
  logic [COLOR_W-1:0]        headCol;
  logic                      headNew, headClose;

  state_t                    state_q;
  logic signed [COORD_W-1:0] cx_q, cy_q, tx_q, ty_q, ox_q, oy_q;
  logic                      haveOrigin_q, start_q, close_q;
  logic [COLOR_W-1:0]        col_q;
  logic signed [DW-1:0]      dx_q, dy_q;
  logic                      sxNeg_q, syNeg_q;
  logic signed [EW-1:0]      err_q;
  logic [DW-1:0]             cnt_q;
  logic                      pxValid_q, pxLast_q;
  logic signed [COORD_W-1:0] pxX_q, pxY_q;
  logic [COLOR_W-1:0]        pxCol_q;

  assign fifoEmpty    = (wrPtr_q == rdPtr_q);
  assign fifoFull     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pt_ready_out = readyEn_q && !fifoFull;
  assign push         = pt_valid_in && pt_ready_out;
  assign advance      = !pxValid_q || px_ready_in;
  assign pop          = (state_q == IDLE) && advance && !fifoEmpty;
  assign head         = mem_q[rdPtr_q[AW-1:0]];
  assign {headX, headY, headCol, headNew, headClose} = head;

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= {pt_x_in, pt_y_in, pt_color_in, pt_new_in, pt_close_in};
  end

  // readyEn_q keeps the FIFO closed until the first edge after reset release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      readyEn_q <= 1'b0;
    end else begin
      readyEn_q <= 1'b1;
      if (push) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)  rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // Segment setup: IDLE measures current endpoint -> FIFO head, otherwise endpoint -> origin.
  logic signed [COORD_W-1:0] fromX, fromY, toX, toY;
  logic signed [DW-1:0]      diffX, diffY, absX, absY, negAbsY;
  logic signed [EW-1:0]      setErr;
  logic [DW-1:0]             setCnt, closeCnt;
  logic                      setSxNeg, setSyNeg;

  always_comb begin
    if (state_q == IDLE) begin
      fromX = cx_q;  fromY = cy_q;  toX = headX; toY = headY;
    end else begin
      fromX = tx_q;  fromY = ty_q;  toX = ox_q;  toY = oy_q;
    end
    diffX    = $signed({toX[COORD_W-1], toX}) - $signed({fromX[COORD_W-1], fromX});
    diffY    = $signed({toY[COORD_W-1], toY}) - $signed({fromY[COORD_W-1], fromY});
    absX     = diffX[DW-1] ? -diffX : diffX;
    absY     = diffY[DW-1] ? -diffY : diffY;
    negAbsY  = -absY;
    setSxNeg = diffX[DW-1] || (diffX == '0);
    setSyNeg = diffY[DW-1] || (diffY == '0);
    setErr   = $signed({absX[DW-1], absX}) + $signed({negAbsY[DW-1], negAbsY});
    setCnt   = (absX > absY) ? absX : absY;
    closeCnt = (setCnt == '0) ? '0 : setCnt - CNT_ONE;
  end

  logic signed [EW-1:0]      e2, dxExt, dyExt, stepErr;
  logic signed [COORD_W-1:0] stepX, stepY, pixX, pixY;
  logic                      emitNow, lastNow;

  always_comb begin
    e2      = err_q <<< 1;
    dxExt   = $signed({dx_q[DW-1], dx_q});
    dyExt   = $signed({dy_q[DW-1], dy_q});
    stepErr = err_q;
    stepX   = cx_q;
    stepY   = cy_q;
    if (e2 >= dyExt) begin
      stepErr = stepErr + dyExt;
      stepX   = sxNeg_q ? cx_q - ONE : cx_q + ONE;
    end
    if (e2 <= dxExt) begin
      stepErr = stepErr + dxExt;
      stepY   = syNeg_q ? cy_q - ONE : cy_q + ONE;
    end
    emitNow = start_q || (cnt_q != '0);
    lastNow = start_q || (cnt_q == CNT_ONE);
    pixX    = start_q ? tx_q : stepX;
    pixY    = start_q ? ty_q : stepY;
  end

  // Engine: nothing moves while a presented pixel is being held back.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      cx_q         <= '0;  cy_q <= '0;  tx_q <= '0;  ty_q <= '0;
      ox_q         <= '0;  oy_q <= '0;
      haveOrigin_q <= 1'b0;
      start_q      <= 1'b0;
      close_q      <= 1'b0;
      col_q        <= '0;
      dx_q         <= '0;  dy_q <= '0;
      sxNeg_q      <= 1'b0;
      syNeg_q      <= 1'b0;
      err_q        <= '0;
      cnt_q        <= '0;
      pxValid_q    <= 1'b0;
      pxLast_q     <= 1'b0;
      pxX_q        <= '0;  pxY_q <= '0;
      pxCol_q      <= '0;
    end else if (advance) begin
      pxValid_q <= 1'b0;
      case (state_q)
        IDLE: if (!fifoEmpty) begin
          tx_q    <= headX;
          ty_q    <= headY;
          col_q   <= headCol;
          close_q <= headClose;
          start_q <= headNew || !haveOrigin_q;
          if (headNew || !haveOrigin_q) begin
            ox_q         <= headX;
            oy_q         <= headY;
            haveOrigin_q <= 1'b1;
          end
          dx_q    <= absX;
          dy_q    <= negAbsY;
          sxNeg_q <= setSxNeg;
          syNeg_q <= setSyNeg;
          err_q   <= setErr;
          cnt_q   <= setCnt;
          state_q <= LOAD;
        end
        LOAD, DRAW: begin
          if (emitNow) begin
            pxValid_q <= 1'b1;
            pxX_q     <= pixX;
            pxY_q     <= pixY;
            pxCol_q   <= col_q;
            pxLast_q  <= lastNow;
            cx_q      <= pixX;
            cy_q      <= pixY;
            err_q     <= stepErr;
            cnt_q     <= cnt_q - CNT_ONE;
          end
          if (emitNow && !lastNow) begin
            state_q <= DRAW;
          end else if (close_q) begin
            dx_q    <= absX;
            dy_q    <= negAbsY;
            sxNeg_q <= setSxNeg;
            syNeg_q <= setSyNeg;
            err_q   <= setErr;
            cnt_q   <= closeCnt;
            state_q <= CLOSE;
          end else begin
            state_q <= IDLE;
          end
        end
        CLOSE: begin
          if (cnt_q != '0) begin
            pxValid_q <= 1'b1;
            pxX_q     <= stepX;
            pxY_q     <= stepY;
            pxCol_q   <= col_q;
            pxLast_q  <= (cnt_q == CNT_ONE);
            cx_q      <= stepX;
            cy_q      <= stepY;
            err_q     <= stepErr;
            cnt_q     <= cnt_q - CNT_ONE;
          end
          if (cnt_q <= CNT_ONE) begin
            cx_q    <= ox_q;
            cy_q    <= oy_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign px_valid_out    = pxValid_q;
  assign px_x_out        = pxX_q;
  assign px_y_out        = pxY_q;
  assign px_color_out    = pxCol_q;
  assign px_seg_last_out = pxLast_q;
  assign busy_out        = !fifoEmpty || (state_q != IDLE) || pxValid_q;
endmodule

// File: tb/tb_polyline_gen.sv
// Directed testbench for polyline_gen: one task per scenario, each comparing
// the captured pixel stream against hand-derived Bresenham results.
`timescale 1ns/1ps
module tb_polyline_gen;
  localparam int COORD_W    = 12;
  localparam int COLOR_W    = 4;
  localparam int FIFO_DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      pt_valid = 1'b0;
  logic                      pt_ready_out;
  logic signed [COORD_W-1:0] pt_x = '0, pt_y = '0;
  logic [COLOR_W-1:0]        pt_color = '0;
  logic                      pt_new = 1'b0, pt_close = 1'b0;
  logic                      px_valid_out;
  logic                      px_ready = 1'b1;
  logic signed [COORD_W-1:0] px_x_out, px_y_out;
  logic [COLOR_W-1:0]        px_color_out;
  logic                      px_seg_last_out;
  logic                      busy_out;

  typedef struct {
    int x;
    int y;
    int col;
    int last;
  } pix_t;

  pix_t pxQ[$];
  pix_t mon;
  int   tests = 0;
  int   failed = 0;
  int   ptAccepted = 0;

  polyline_gen #(.COORD_W(COORD_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .pt_valid_in(pt_valid), .pt_ready_out(pt_ready_out),
    .pt_x_in(pt_x), .pt_y_in(pt_y), .pt_color_in(pt_color),
    .pt_new_in(pt_new), .pt_close_in(pt_close),
    .px_valid_out(px_valid_out), .px_ready_in(px_ready),
    .px_x_out(px_x_out), .px_y_out(px_y_out), .px_color_out(px_color_out),
    .px_seg_last_out(px_seg_last_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // Inputs change only 1ns after a rising edge, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (rst_n && px_valid_out && px_ready) begin
      mon.x    = $signed(px_x_out);
      mon.y    = $signed(px_y_out);
      mon.col  = px_color_out;
      mon.last = px_seg_last_out;
      pxQ.push_back(mon);
    end
    if (rst_n && pt_valid && pt_ready_out) ptAccepted++;
  end

  task automatic pushPoint(input int x, input int y, input int col, input bit nw, input bit cl);
    int k = 0;
    @(posedge clk); #1;
    pt_valid = 1'b1;
    pt_x     = COORD_W'(x);
    pt_y     = COORD_W'(y);
    pt_color = COLOR_W'(col);
    pt_new   = nw;
    pt_close = cl;
    @(negedge clk);
    while (!pt_ready_out && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!pt_ready_out) begin
      tests++;
      failed++;
      $display("[TB] FAIL push_timeout: point (%0d,%0d) not accepted, pt_ready_out=%b expected 1", x, y, pt_ready_out);
    end
    @(posedge clk); #1;
    pt_valid = 1'b0;
  endtask

  task automatic waitPixels(input int n);
    int k = 0;
    while (pxQ.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    px_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (px_valid_out !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: got %b, expected 0", px_valid_out); end
    tests++;
    if (pt_ready_out !== 1'b0) begin failed++; $display("[TB] FAIL reset_ptready: got %b, expected 0", pt_ready_out); end
    tests++;
    if (busy_out !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_out); end
    tests++;
    if ({px_x_out, px_y_out, px_color_out, px_seg_last_out} !== '0)
      begin failed++; $display("[TB] FAIL reset_pxfields: got x=%0d y=%0d c=%0d l=%b, expected all 0", px_x_out, px_y_out, px_color_out, px_seg_last_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (pt_ready_out !== 1'b0) begin failed++; $display("[TB] FAIL reset_ready_early: got %b, expected 0", pt_ready_out); end
    @(posedge clk); #1;
    tests++;
    if (pt_ready_out !== 1'b1) begin failed++; $display("[TB] FAIL reset_ready_rise: got %b, expected 1", pt_ready_out); end
  endtask

  task automatic test_latency();
    px_ready = 1'b1;
    pxQ.delete();
    pushPoint(7, -2, 5, 1'b1, 1'b0);
    tests++;
    if (px_valid_out !== 1'b0) begin failed++; $display("[TB] FAIL latency_n0: valid got %b, expected 0", px_valid_out); end
    @(posedge clk); #1;
    tests++;
    if (px_valid_out !== 1'b0) begin failed++; $display("[TB] FAIL latency_n1: valid got %b, expected 0", px_valid_out); end
    @(posedge clk); #1;
    tests++;
    if (px_valid_out !== 1'b1 || $signed(px_x_out) != 7 || $signed(px_y_out) != -2 || px_color_out !== 4'd5 || px_seg_last_out !== 1'b1)
      begin failed++; $display("[TB] FAIL latency_n2: got v=%b (%0d,%0d) c=%0d l=%b, expected v=1 (7,-2) c=5 l=1",
                               px_valid_out, $signed(px_x_out), $signed(px_y_out), px_color_out, px_seg_last_out); end
    waitPixels(1);
    tests++;
    if (pxQ.size() != 1 || busy_out !== 1'b0) begin failed++; $display("[TB] FAIL latency_count: got %0d pixels busy=%b, expected 1 busy=0", pxQ.size(), busy_out); end
  endtask

  task automatic test_line();
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{0, 1, 1, 2, 2};
    int ec[5] = '{1, 2, 2, 2, 2};
    int el[5] = '{1, 0, 0, 0, 1};
    px_ready = 1'b1;
    pxQ.delete();
    pushPoint(0, 0, 1, 1'b1, 1'b0);
    pushPoint(4, 2, 2, 1'b0, 1'b0);
    waitPixels(5);
    tests++;
    if (pxQ.size() != 5) begin failed++; $display("[TB] FAIL line_count: got %0d pixels, expected 5", pxQ.size()); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= pxQ.size()) begin failed++; $display("[TB] FAIL line_px%0d: got nothing, expected (%0d,%0d)", i, ex[i], ey[i]); end
      else if (pxQ[i].x != ex[i] || pxQ[i].y != ey[i] || pxQ[i].col != ec[i] || pxQ[i].last != el[i])
        begin failed++; $display("[TB] FAIL line_px%0d: got (%0d,%0d) c=%0d l=%0d, expected (%0d,%0d) c=%0d l=%0d",
                                 i, pxQ[i].x, pxQ[i].y, pxQ[i].col, pxQ[i].last, ex[i], ey[i], ec[i], el[i]); end
    end
  endtask

  task automatic test_triangle();
    int ex[6] = '{0, 1, 2, 2, 2, 1};
    int ey[6] = '{0, 0, 0, 1, 2, 1};
    int ec[6] = '{3, 4, 4, 5, 5, 5};
    int el[6] = '{1, 0, 1, 0, 1, 1};
    px_ready = 1'b1;
    pxQ.delete();
    pushPoint(0, 0, 3, 1'b1, 1'b0);
    pushPoint(2, 0, 4, 1'b0, 1'b0);
    pushPoint(2, 2, 5, 1'b0, 1'b1);
    waitPixels(6);
    tests++;
    if (pxQ.size() != 6) begin failed++; $display("[TB] FAIL tri_count: got %0d pixels, expected 6", pxQ.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= pxQ.size()) begin failed++; $display("[TB] FAIL tri_px%0d: got nothing, expected (%0d,%0d)", i, ex[i], ey[i]); end
      else if (pxQ[i].x != ex[i] || pxQ[i].y != ey[i] || pxQ[i].col != ec[i] || pxQ[i].last != el[i])
        begin failed++; $display("[TB] FAIL tri_px%0d: got (%0d,%0d) c=%0d l=%0d, expected (%0d,%0d) c=%0d l=%0d",
                                 i, pxQ[i].x, pxQ[i].y, pxQ[i].col, pxQ[i].last, ex[i], ey[i], ec[i], el[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [2*COORD_W+COLOR_W:0] held;
    int k = 0;
    px_ready = 1'b1;
    pxQ.delete();
    pushPoint(0, 0, 6, 1'b1, 1'b0);
    pushPoint(6, 0, 7, 1'b0, 1'b0);
    while (pxQ.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    px_ready = 1'b0;
    held = {px_x_out, px_y_out, px_color_out, px_seg_last_out};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (px_valid_out !== 1'b1 || {px_x_out, px_y_out, px_color_out, px_seg_last_out} !== held)
        begin failed++; $display("[TB] FAIL bp_hold%0d: got v=%b fields=%h, expected v=1 fields=%h",
                                 c, px_valid_out, {px_x_out, px_y_out, px_color_out, px_seg_last_out}, held); end
      @(posedge clk); #1;
    end
    px_ready = 1'b1;
    waitPixels(7);
    tests++;
    if (pxQ.size() != 7) begin failed++; $display("[TB] FAIL bp_count: got %0d pixels, expected 7", pxQ.size()); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (i >= pxQ.size()) begin failed++; $display("[TB] FAIL bp_px%0d: got nothing, expected (%0d,0)", i, i); end
      else if (pxQ[i].x != i || pxQ[i].y != 0 || pxQ[i].col != (i == 0 ? 6 : 7) || pxQ[i].last != ((i == 0 || i == 6) ? 1 : 0))
        begin failed++; $display("[TB] FAIL bp_px%0d: got (%0d,%0d) c=%0d l=%0d, expected (%0d,0)",
                                 i, pxQ[i].x, pxQ[i].y, pxQ[i].col, pxQ[i].last, i); end
    end
  endtask

  task automatic test_fifo_full();
    int base;
    px_ready = 1'b0;
    pxQ.delete();
    base = ptAccepted;
    fork
      begin
        for (int i = 0; i < FIFO_DEPTH + 2; i++) pushPoint(10 + i, 10, i + 1, i == 0, 1'b0);
      end
      begin
        repeat (24) @(posedge clk);
        @(negedge clk);
        tests++;
        if (pt_ready_out !== 1'b0) begin failed++; $display("[TB] FAIL full_ready: got %b, expected 0", pt_ready_out); end
        tests++;
        if (ptAccepted - base != FIFO_DEPTH + 1)
          begin failed++; $display("[TB] FAIL full_accepted: got %0d points, expected %0d", ptAccepted - base, FIFO_DEPTH + 1); end
        @(posedge clk); #1;
        px_ready = 1'b1;
      end
    join
    waitPixels(FIFO_DEPTH + 2);
    tests++;
    if (pxQ.size() != FIFO_DEPTH + 2) begin failed++; $display("[TB] FAIL full_count: got %0d pixels, expected %0d", pxQ.size(), FIFO_DEPTH + 2); end
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      tests++;
      if (i >= pxQ.size()) begin failed++; $display("[TB] FAIL full_px%0d: got nothing, expected (%0d,10)", i, 10 + i); end
      else if (pxQ[i].x != 10 + i || pxQ[i].y != 10 || pxQ[i].col != i + 1 || pxQ[i].last != 1)
        begin failed++; $display("[TB] FAIL full_px%0d: got (%0d,%0d) c=%0d l=%0d, expected (%0d,10) c=%0d l=1",
                                 i, pxQ[i].x, pxQ[i].y, pxQ[i].col, pxQ[i].last, 10 + i, i + 1); end
    end
  endtask

  task automatic test_negative();
    int ex[3] = '{-3, -4, -5};
    int ec[3] = '{8, 10, 10};
    int el[3] = '{1, 0, 1};
    px_ready = 1'b1;
    pxQ.delete();
    pushPoint(-3, -1, 8, 1'b1, 1'b0);
    pushPoint(-3, -1, 9, 1'b0, 1'b0);
    pushPoint(-5, -1, 10, 1'b0, 1'b0);
    waitPixels(3);
    tests++;
    if (pxQ.size() != 3) begin failed++; $display("[TB] FAIL neg_count: got %0d pixels, expected 3", pxQ.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= pxQ.size()) begin failed++; $display("[TB] FAIL neg_px%0d: got nothing, expected (%0d,-1)", i, ex[i]); end
      else if (pxQ[i].x != ex[i] || pxQ[i].y != -1 || pxQ[i].col != ec[i] || pxQ[i].last != el[i])
        begin failed++; $display("[TB] FAIL neg_px%0d: got (%0d,%0d) c=%0d l=%0d, expected (%0d,-1) c=%0d l=%0d",
                                 i, pxQ[i].x, pxQ[i].y, pxQ[i].col, pxQ[i].last, ex[i], ec[i], el[i]); end
    end
  endtask

  task automatic test_reset_mid_draw();
    int k = 0;
    px_ready = 1'b1;
    pxQ.delete();
    pushPoint(0, 0, 1, 1'b1, 1'b0);
    pushPoint(20, 0, 2, 1'b0, 1'b0);
    while (pxQ.size() < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (px_valid_out !== 1'b0 || busy_out !== 1'b0 || pt_ready_out !== 1'b0)
      begin failed++; $display("[TB] FAIL midreset_outputs: got valid=%b busy=%b ready=%b, expected 0 0 0", px_valid_out, busy_out, pt_ready_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (pt_ready_out !== 1'b0) begin failed++; $display("[TB] FAIL midreset_ready_early: got %b, expected 0", pt_ready_out); end
    @(posedge clk); #1;
    tests++;
    if (pt_ready_out !== 1'b1) begin failed++; $display("[TB] FAIL midreset_ready_rise: got %b, expected 1", pt_ready_out); end
    pxQ.delete();
    pushPoint(5, 5, 11, 1'b0, 1'b0);
    waitPixels(1);
    tests++;
    if (pxQ.size() != 1) begin failed++; $display("[TB] FAIL midreset_count: got %0d pixels, expected 1", pxQ.size()); end
    else if (pxQ[0].x != 5 || pxQ[0].y != 5 || pxQ[0].col != 11 || pxQ[0].last != 1)
      begin failed++; $display("[TB] FAIL midreset_px: got (%0d,%0d) c=%0d l=%0d, expected (5,5) c=11 l=1",
                               pxQ[0].x, pxQ[0].y, pxQ[0].col, pxQ[0].last); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_line();
    test_triangle();
    test_backpressure();
    test_fifo_full();
    test_negative();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/polyline_gen.md
POLYLINE_GEN -- requirements
Module: polyline_gen

Interface
REQ-001 SHALL have parameter COORD_W, default 12, signed two's-complement width of each coordinate.
REQ-002 SHALL have parameter COLOR_W, default 4, width of colour tag.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), number of points buffered.
REQ-004 SHALL have port clk_in  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports pt_valid_in input 1 / pt_ready_out output 1: point handshake; transfer when both high at a clock edge.
REQ-007 SHALL have ports pt_x_in, pt_y_in  input  COORD_W  point coordinates.
REQ-008 SHALL have port pt_color_in  input  COLOR_W  point colour.
REQ-009 SHALL have port pt_new_in  input  1  point starts a new strip (pen-up move).
REQ-010 SHALL have port pt_close_in  input  1  after this point, draw a closing segment back to the strip's first point.
REQ-011 SHALL have ports px_valid_out output 1 / px_ready_in input 1: pixel handshake; transfer when both high.
REQ-012 SHALL have ports px_x_out, px_y_out  output  COORD_W  pixel coordinates.
REQ-013 SHALL have port px_color_out  output  COLOR_W  pixel colour.
REQ-014 SHALL have port px_seg_last_out  output  1  pixel is the final pixel of its segment.
REQ-015 SHALL have port busy_out  output  1  FIFO non-empty, engine not IDLE, or px_valid_out high.

Function
REQ-016 SHALL buffer accepted points in a FIFO_DEPTH FIFO; pt_ready_out = FIFO not full; pt_ready_out has no combinational path from px_ready_in.
REQ-017 SHALL use engine states IDLE, LOAD, DRAW, CLOSE: IDLE->LOAD when FIFO non-empty (pop one point); LOAD->DRAW; DRAW->IDLE on last segment pixel when the point's close flag is clear, else DRAW->CLOSE; CLOSE->IDLE on last closing pixel or immediately if nothing to emit.
REQ-018 SHALL treat the first point after reset, or any point with pt_new_in=1, as a strip start: emit exactly one pixel at that point with px_seg_last_out=1, record it as strip origin.
REQ-019 SHALL for other points draw from the previous endpoint (exclusive) to the new point (inclusive); a point equal to the previous endpoint emits nothing and is consumed.
REQ-020 SHALL for the closing segment draw from the current endpoint (exclusive) to the strip origin (exclusive), colour = closing point's colour; the last emitted pixel carries px_seg_last_out=1.
REQ-021 SHALL step per Bresenham: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 if end>start else -1, err=dx+dy; per step e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy; both may apply in one step.
REQ-022 SHALL size dx, dy to COORD_W+1 bits and err, e2 to COORD_W+2 bits, signed; no overflow for any pair of COORD_W inputs.
REQ-023 SHALL give each segment's pixels the colour of its endpoint point.
REQ-024 SHALL register all px_* outputs; when px_valid_out=1 and px_ready_in=0, px_* outputs hold stable and no state advances.
REQ-025 SHALL sustain one pixel per cycle while px_ready_in=1.
REQ-026 SHALL, with FIFO empty and engine IDLE, raise px_valid_out for a point accepted at edge N after edge N+2.
REQ-027 SHALL accept and drop no point; a point arriving while the engine draws waits in the FIFO.
REQ-028 SHALL not check coordinate range; negative coordinates are drawn like any others.

Reset
REQ-029 SHALL, while rst_n_in=0, asynchronously force: px_valid_out=0, px_x_out=0, px_y_out=0, px_color_out=0, px_seg_last_out=0, busy_out=0, pt_ready_out=0, FIFO empty, state IDLE, strip-origin flag cleared.
REQ-030 SHALL raise pt_ready_out on the first clock edge after rst_n_in rises; reset mid-segment discards all buffered points and partial segments.

Verification
REQ-031 SHALL cover: assert rst_n_in mid-DRAW -> px_valid_out=0 immediately, busy_out=0; after release pt_ready_out=1 one edge later.
REQ-032 SHALL cover: (0,0,new) then (4,2), px_ready_in=1 -> pixels (0,0),(1,1),(2,1),(3,2),(4,2), seg_last on (0,0) and (4,2).
REQ-033 SHALL cover: triangle (0,0,new),(2,0),(2,2,close) -> (0,0),(1,0),(2,0),(2,1),(2,2),(1,1); (0,0) not repeated; seg_last on (1,1).
REQ-034 SHALL cover: px_ready_in low 3 cycles mid-segment -> px_* held constant, no pixel lost or duplicated.
REQ-035 SHALL cover: px_ready_in held low, push FIFO_DEPTH+2 points -> pt_ready_out low once FIFO full, no point lost after release.
REQ-036 SHALL cover: (-3,-1,new) then (-3,-1) then (-5,-1) -> (-3,-1),(-4,-1),(-5,-1); duplicate point emits nothing.
